// File: rtl/xdn_pkg.sv
// Shared constants for the XDN control path: opcodes, control-word bit indices and T-states.
package xdn_pkg;

   localparam int unsigned CTL_WIDTH = 16;
   typedef logic [CTL_WIDTH-1:0] ctl_word_t;

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_LDA = 4'd1;
   localparam logic [3:0] OP_ADD = 4'd2;
   localparam logic [3:0] OP_SUB = 4'd3;
   localparam logic [3:0] OP_STA = 4'd4;
   localparam logic [3:0] OP_LDI = 4'd5;
   localparam logic [3:0] OP_JMP = 4'd6;
   localparam logic [3:0] OP_JC  = 4'd7;
   localparam logic [3:0] OP_JZ  = 4'd8;
   localparam logic [3:0] OP_OUT = 4'd14;
   localparam logic [3:0] OP_HLT = 4'd15;

   localparam int unsigned CTL_HLT      = 0;
   localparam int unsigned CTL_MAR_IN   = 1;
   localparam int unsigned CTL_RAM_IN   = 2;
   localparam int unsigned CTL_RAM_OUT  = 3;
   localparam int unsigned CTL_IR_IN    = 4;
   localparam int unsigned CTL_IR_OUT   = 5;
   localparam int unsigned CTL_A_IN     = 6;
   localparam int unsigned CTL_A_OUT    = 7;
   localparam int unsigned CTL_ALU_OUT  = 8;
   localparam int unsigned CTL_ALU_SUB  = 9;
   localparam int unsigned CTL_B_IN     = 10;
   localparam int unsigned CTL_OUT_IN   = 11;
   localparam int unsigned CTL_PC_COUNT = 12;
   localparam int unsigned CTL_PC_OUT   = 13;
   localparam int unsigned CTL_PC_JUMP  = 14;
   localparam int unsigned CTL_FLAGS_IN = 15;

   localparam logic [2:0] T0 = 3'd0;
   localparam logic [2:0] T1 = 3'd1;
   localparam logic [2:0] T2 = 3'd2;
   localparam logic [2:0] T3 = 3'd3;
   localparam logic [2:0] T4 = 3'd4;

   // Strobes that put a value on the shared BUS; at most one may be active per step.
   localparam ctl_word_t CTL_BUS_DRIVERS = (ctl_word_t'(1) << CTL_PC_OUT)
                                         | (ctl_word_t'(1) << CTL_RAM_OUT)
                                         | (ctl_word_t'(1) << CTL_IR_OUT)
                                         | (ctl_word_t'(1) << CTL_A_OUT)
                                         | (ctl_word_t'(1) << CTL_ALU_OUT);

   function automatic ctl_word_t ctl_bit(input int unsigned idx);
      return ctl_word_t'(1) << idx;
   endfunction

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode: maps (opcode, T-state, flags) to the control word and end-of-instruction.
module microcode_rom
   import xdn_pkg::*;
#(
   parameter int unsigned OPCODE_WIDTH = 4
) (
   input  logic [OPCODE_WIDTH-1:0] opcode,
   input  logic [2:0]              step,
   input  logic                    carry,
   input  logic                    zero,
   output logic [15:0]             control,
   output logic                    done
);

   always_comb begin
      control = '0;
      done    = 1'b0;
      case (step)
         T0: control = ctl_bit(CTL_PC_OUT) | ctl_bit(CTL_MAR_IN);
         T1: control = ctl_bit(CTL_RAM_OUT) | ctl_bit(CTL_IR_IN) | ctl_bit(CTL_PC_COUNT);
         T2: begin
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_STA:
                  control = ctl_bit(CTL_IR_OUT) | ctl_bit(CTL_MAR_IN);
               OP_LDI: begin
                  control = ctl_bit(CTL_IR_OUT) | ctl_bit(CTL_A_IN);
                  done    = 1'b1;
               end
               OP_JMP: begin
                  control = ctl_bit(CTL_IR_OUT) | ctl_bit(CTL_PC_JUMP);
                  done    = 1'b1;
               end
               OP_JC: begin
                  if (carry) control = ctl_bit(CTL_IR_OUT) | ctl_bit(CTL_PC_JUMP);
                  done = 1'b1;
               end
               OP_JZ: begin
                  if (zero) control = ctl_bit(CTL_IR_OUT) | ctl_bit(CTL_PC_JUMP);
                  done = 1'b1;
               end
               OP_OUT: begin
                  control = ctl_bit(CTL_A_OUT) | ctl_bit(CTL_OUT_IN);
                  done    = 1'b1;
               end
               // Not done: the sequencer parks in T2 once halt latches.
               OP_HLT: control = ctl_bit(CTL_HLT);
               // NOP and the unassigned opcodes 9..13.
               default: done = 1'b1;
            endcase
         end
         T3: begin
            case (opcode)
               OP_LDA: begin
                  control = ctl_bit(CTL_RAM_OUT) | ctl_bit(CTL_A_IN);
                  done    = 1'b1;
               end
               OP_ADD, OP_SUB: control = ctl_bit(CTL_RAM_OUT) | ctl_bit(CTL_B_IN);
               OP_STA: begin
                  control = ctl_bit(CTL_A_OUT) | ctl_bit(CTL_RAM_IN);
                  done    = 1'b1;
               end
               default: done = 1'b1;
            endcase
         end
         default: begin
            // T4 and any unreachable step always terminate the instruction.
            done = 1'b1;
            if (opcode == OP_ADD || opcode == OP_SUB) begin
               control = ctl_bit(CTL_ALU_OUT) | ctl_bit(CTL_A_IN) | ctl_bit(CTL_FLAGS_IN);
            end
            if (opcode == OP_SUB) control = control | ctl_bit(CTL_ALU_SUB);
         end
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// T-state sequencer: step register and sticky halt flag around the microcode ROM.
module control_sequencer
   import xdn_pkg::*;
#(
   parameter int unsigned OPCODE_WIDTH = 4,
   parameter int unsigned MAX_STEP     = 4
) (
   input  logic                    i_CLOCK,
   input  logic                    i_CLEAR,
   input  logic [OPCODE_WIDTH-1:0] i_OPCODE,
   input  logic                    i_FLAG_CARRY,
   input  logic                    i_FLAG_ZERO,
   output logic [15:0]             o_CONTROL,
   output logic [2:0]              o_STEP,
   output logic                    o_INSTR_DONE,
   output logic                    o_HALTED
);

   localparam logic [2:0] LAST_STEP = 3'(MAX_STEP);

   logic [2:0]  step_q, step_d;
   logic        halt_q, halt_d;
   logic [15:0] rom_control;
   logic        rom_done;
   logic        at_last;

   microcode_rom #(
      .OPCODE_WIDTH(OPCODE_WIDTH)
   ) u_rom (
      .opcode  (i_OPCODE),
      .step    (step_q),
      .carry   (i_FLAG_CARRY),
      .zero    (i_FLAG_ZERO),
      .control (rom_control),
      .done    (rom_done)
   );

   assign at_last = (step_q >= LAST_STEP);

   always_comb begin
      step_d       = step_q;
      halt_d       = halt_q;
      if (halt_q) begin
         step_d = T2;
      end else if (rom_control[CTL_HLT]) begin
         halt_d = 1'b1;
      end else if (rom_done || at_last) begin
         step_d = T0;
      end else begin
         step_d = step_q + 3'd1;
      end

      // Once halted the opcode is ignored so the bus stays quiet until cleared.
      o_CONTROL    = halt_q ? ctl_bit(CTL_HLT) : rom_control;
      o_INSTR_DONE = ~halt_q & (rom_done | at_last);
      o_HALTED     = halt_q;
   end

   assign o_STEP = step_q;

   always_ff @(posedge i_CLOCK or posedge i_CLEAR) begin
      if (i_CLEAR) begin
         step_q <= T0;
         halt_q <= 1'b0;
      end else begin
         step_q <= step_d;
         halt_q <= halt_d;
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: stimulus pushes expected micro-steps, a negedge monitor pops and compares.
module tb_control_sequencer;

   localparam logic [15:0] HLT      = 16'h0001;
   localparam logic [15:0] MAR_IN   = 16'h0002;
   localparam logic [15:0] RAM_IN   = 16'h0004;
   localparam logic [15:0] RAM_OUT  = 16'h0008;
   localparam logic [15:0] IR_IN    = 16'h0010;
   localparam logic [15:0] IR_OUT   = 16'h0020;
   localparam logic [15:0] A_IN     = 16'h0040;
   localparam logic [15:0] A_OUT    = 16'h0080;
   localparam logic [15:0] ALU_OUT  = 16'h0100;
   localparam logic [15:0] ALU_SUB  = 16'h0200;
   localparam logic [15:0] B_IN     = 16'h0400;
   localparam logic [15:0] OUT_IN   = 16'h0800;
   localparam logic [15:0] PC_COUNT = 16'h1000;
   localparam logic [15:0] PC_OUT   = 16'h2000;
   localparam logic [15:0] PC_JUMP  = 16'h4000;
   localparam logic [15:0] FLAGS_IN = 16'h8000;
   localparam logic [15:0] BUS_MASK = PC_OUT | RAM_OUT | IR_OUT | A_OUT | ALU_OUT;

   typedef struct {
      logic [2:0]  step;
      logic [15:0] ctl;
      logic        done;
      logic        halted;
   } exp_t;

   logic        i_CLOCK;
   logic        i_CLEAR;
   logic [3:0]  i_OPCODE;
   logic        i_FLAG_CARRY;
   logic        i_FLAG_ZERO;
   logic [15:0] o_CONTROL;
   logic [2:0]  o_STEP;
   logic        o_INSTR_DONE;
   logic        o_HALTED;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   control_sequencer #(
      .OPCODE_WIDTH(4),
      .MAX_STEP(4)
   ) dut (
      .i_CLOCK      (i_CLOCK),
      .i_CLEAR      (i_CLEAR),
      .i_OPCODE     (i_OPCODE),
      .i_FLAG_CARRY (i_FLAG_CARRY),
      .i_FLAG_ZERO  (i_FLAG_ZERO),
      .o_CONTROL    (o_CONTROL),
      .o_STEP       (o_STEP),
      .o_INSTR_DONE (o_INSTR_DONE),
      .o_HALTED     (o_HALTED)
   );

   initial i_CLOCK = 1'b0;
   always #5 i_CLOCK = ~i_CLOCK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the ordered list of control words an instruction issues.
   task automatic push_instr(input logic [3:0] op, input logic c, input logic z, output int n);
      logic [15:0] w[$];
      w = {};
      w.push_back(PC_OUT | MAR_IN);
      w.push_back(RAM_OUT | IR_IN | PC_COUNT);
      case (op)
         4'd1: begin w.push_back(IR_OUT | MAR_IN); w.push_back(RAM_OUT | A_IN); end
         4'd2, 4'd3: begin
            w.push_back(IR_OUT | MAR_IN);
            w.push_back(RAM_OUT | B_IN);
            w.push_back(ALU_OUT | A_IN | FLAGS_IN | ((op == 4'd3) ? ALU_SUB : 16'h0));
         end
         4'd4: begin w.push_back(IR_OUT | MAR_IN); w.push_back(A_OUT | RAM_IN); end
         4'd5: w.push_back(IR_OUT | A_IN);
         4'd6: w.push_back(IR_OUT | PC_JUMP);
         4'd7: w.push_back(c ? (IR_OUT | PC_JUMP) : 16'h0);
         4'd8: w.push_back(z ? (IR_OUT | PC_JUMP) : 16'h0);
         4'd14: w.push_back(A_OUT | OUT_IN);
         default: w.push_back(16'h0);
      endcase
      n = w.size();
      for (int i = 0; i < n; i++) begin
         exp_q.push_back('{step: 3'(i), ctl: w[i], done: (i == n - 1), halted: 1'b0});
      end
   endtask

   // Called just after a rising edge; returns just after the edge that starts the next one.
   task automatic run_instr(input logic [3:0] op, input logic c, input logic z);
      int n;
      i_OPCODE     = op;
      i_FLAG_CARRY = c;
      i_FLAG_ZERO  = z;
      push_instr(op, c, z, n);
      repeat (n) @(posedge i_CLOCK);
      #1;
   endtask

   task automatic pulse_clear(input string name);
      i_CLEAR = 1'b1;
      #1;
      check({name, "_step"}, 32'(o_STEP), 32'd0);
      check({name, "_ctl"}, 32'(o_CONTROL), 32'h2002);
      check({name, "_halted"}, 32'(o_HALTED), 32'd0);
      check({name, "_done"}, 32'(o_INSTR_DONE), 32'd0);
      #1;
      i_CLEAR = 1'b0;
   endtask

   task automatic run_halt(input logic c, input logic z);
      i_OPCODE     = 4'd15;
      i_FLAG_CARRY = c;
      i_FLAG_ZERO  = z;
      exp_q.push_back('{step: 3'd0, ctl: PC_OUT | MAR_IN, done: 1'b0, halted: 1'b0});
      exp_q.push_back('{step: 3'd1, ctl: RAM_OUT | IR_IN | PC_COUNT, done: 1'b0, halted: 1'b0});
      exp_q.push_back('{step: 3'd2, ctl: HLT, done: 1'b0, halted: 1'b0});
      for (int i = 0; i < 20; i++) begin
         exp_q.push_back('{step: 3'd2, ctl: HLT, done: 1'b0, halted: 1'b1});
      end
      repeat (3) @(posedge i_CLOCK);
      #1;
      // Opcode and flags must be ignored while halted.
      i_OPCODE     = 4'($urandom_range(0, 14));
      i_FLAG_CARRY = 1'($urandom);
      i_FLAG_ZERO  = 1'($urandom);
      repeat (20) @(posedge i_CLOCK);
      #1;
      pulse_clear("halt_exit");
   endtask

   // Monitor: the DUT presents a control word every step.
   always @(negedge i_CLOCK) begin
      check("bus_drivers_le1", 32'($countones(o_CONTROL & BUS_MASK) <= 1), 32'd1);
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("step", 32'(o_STEP), 32'(e.step));
         check("control", 32'(o_CONTROL), 32'(e.ctl));
         check("instr_done", 32'(o_INSTR_DONE), 32'(e.done));
         check("halted", 32'(o_HALTED), 32'(e.halted));
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      i_CLEAR      = 1'b1;
      i_OPCODE     = 4'd0;
      i_FLAG_CARRY = 1'b0;
      i_FLAG_ZERO  = 1'b0;
      #2;
      check("reset_step", 32'(o_STEP), 32'd0);
      check("reset_ctl", 32'(o_CONTROL), 32'h2002);
      check("reset_done", 32'(o_INSTR_DONE), 32'd0);
      check("reset_halted", 32'(o_HALTED), 32'd0);
      @(posedge i_CLOCK);
      #1;
      i_CLEAR = 1'b0;

      run_instr(4'd2, 1'b0, 1'b0);
      run_instr(4'd7, 1'b1, 1'b0);
      run_instr(4'd7, 1'b0, 1'b1);
      run_instr(4'd11, 1'b1, 1'b1);

      // Abort ADD in T3: only T0..T2 are expected before the clear.
      i_OPCODE = 4'd2;
      push_instr(4'd2, 1'b0, 1'b0, n);
      void'(exp_q.pop_back());
      void'(exp_q.pop_back());
      repeat (3) @(posedge i_CLOCK);
      #1;
      check("mid_add_step", 32'(o_STEP), 32'd3);
      pulse_clear("mid_add_clear");

      for (int op = 0; op < 15; op++) begin
         for (int f = 0; f < 4; f++) begin
            run_instr(4'(op), f[0], f[1]);
         end
      end

      for (int i = 0; i < 200; i++) begin
         run_instr(4'($urandom_range(0, 14)), 1'($urandom), 1'($urandom));
      end

      run_halt(1'b0, 1'b0);
      run_instr(4'd3, 1'b1, 1'b0);
      run_halt(1'b1, 1'b1);
      run_instr(4'd8, 1'b0, 1'b1);

      @(posedge i_CLOCK);
      #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
